// File: rtl/serial_checking_sink.sv
// serial_checking_sink_fifo: small first-word-fall-through FIFO with registered occupancy count.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; next count exposed for registered flow control.
module serial_checking_sink_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push_vld,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop_rdy,
    output logic [W-1:0]  o_head_dat,
    output logic          o_head_vld,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_count_nxt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push      = i_push_vld && (r_count != CW'(DEPTH));
    assign w_pop       = i_pop_rdy && (r_count != '0);
    assign o_count     = r_count;
    assign o_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign o_head_vld  = (r_count != '0);
    // Head is forced to zero while empty so stale storage never leaks out
    assign o_head_dat  = o_head_vld ? r_mem[r_rd_ptr] : '0;

    // Storage array: written only, never reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= o_count_nxt;
        end
    end
endmodule

// serial_checking_sink: deserialises 1-bit NoC packets into flits, checks destination vs ID, buffers in a FWFT FIFO.
// Latency: start bit to out_valid is FLIT_BITS+1 cycles; counters update on the FIFO write edge.
// Backpressure: registered busy covers packet+GAP and FIFO-full; packets starting while full are dropped and counted.
module serial_checking_sink #(
    parameter int ID        = 0,
    parameter int FLIT_BITS = 8,
    parameter int DEST_BITS = 4,
    parameter int DEPTH     = 4,
    parameter int GAP       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 busy,
    input  logic                 data,
    output logic [FLIT_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          pkt_count,
    output logic [15:0]          misroute_count,
    output logic [15:0]          drop_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_STORE = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [4:0]           r_cnt;
    logic [4:0]           w_cnt_nxt;
    logic                 r_drop;
    logic                 w_drop_nxt;
    logic [FLIT_BITS-1:0] r_sh;
    logic                 r_busy;
    logic [15:0]          r_pkt_cnt;
    logic [15:0]          r_mis_cnt;
    logic [15:0]          r_drop_cnt;
    logic                 w_push;
    logic                 w_drop_evt;
    logic                 w_misroute;
    logic                 w_full;
    logic [CW-1:0]        w_fifo_count;
    logic [CW-1:0]        w_fifo_count_nxt;

    serial_checking_sink_fifo #(
        .W     (FLIT_BITS),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push_vld  (w_push),
        .i_push_dat  (r_sh),
        .i_pop_rdy   (out_ready),
        .o_head_dat  (out_data),
        .o_head_vld  (out_valid),
        .o_count     (w_fifo_count),
        .o_count_nxt (w_fifo_count_nxt)
    );

    assign w_full         = (w_fifo_count == CW'(DEPTH));
    assign w_misroute     = (r_sh[DEST_BITS-1:0] != DEST_BITS'(ID));
    assign busy           = r_busy;
    assign pkt_count      = r_pkt_cnt;
    assign misroute_count = r_mis_cnt;
    assign drop_count     = r_drop_cnt;

    // Next-state and per-state strobes; the drop decision is taken once, at the start bit
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_drop_nxt  = r_drop;
        w_push      = 1'b0;
        w_drop_evt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (data) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_drop_nxt  = w_full;
                end
            end
            S_SHIFT: begin
                if (r_cnt == 5'(FLIT_BITS - 1)) begin
                    w_state_nxt = S_STORE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            S_STORE: begin
                w_push      = !r_drop;
                w_drop_evt  = r_drop;
                w_cnt_nxt   = '0;
                w_state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (r_cnt == 5'(GAP - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, bit/gap counter, drop flag and registered busy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drop  <= w_drop_nxt;
            r_busy  <= (w_state_nxt != S_IDLE) || (w_fifo_count_nxt == CW'(DEPTH));
        end
    end

    // Payload shifter (LSB arrives first) and wrap-around statistics counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh       <= '0;
            r_pkt_cnt  <= '0;
            r_mis_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (r_state == S_SHIFT) begin
                r_sh <= FLIT_BITS'({data, r_sh} >> 1);
            end
            if (w_push) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
                if (w_misroute) r_mis_cnt <= r_mis_cnt + 16'd1;
            end
            if (w_drop_evt) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_serial_checking_sink.sv
// tb_serial_checking_sink: drives serial packets into two sink instances (GAP=2 and GAP=0).
// Latency: reference model predicts head, busy and counters after every clock edge.
// Backpressure: transmitter waits for busy low except for deliberate forced start bits.
module tb_serial_checking_sink;
    localparam int ID    = 5;
    localparam int FB    = 8;
    localparam int DB    = 4;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          data;
    logic          out_ready;
    logic          busy;
    logic          out_valid;
    logic [FB-1:0] out_data;
    logic [15:0]   pkt_count;
    logic [15:0]   misroute_count;
    logic [15:0]   drop_count;

    logic          data0;
    logic          out_ready0;
    logic          busy0;
    logic          out_valid0;
    logic [FB-1:0] out_data0;
    logic [15:0]   pkt_count0;
    logic [15:0]   misroute_count0;
    logic [15:0]   drop_count0;

    always #5 clk = ~clk;

    serial_checking_sink #(.ID(ID), .FLIT_BITS(FB), .DEST_BITS(DB), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .busy(busy), .data(data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .pkt_count(pkt_count), .misroute_count(misroute_count), .drop_count(drop_count)
    );

    serial_checking_sink #(.ID(ID), .FLIT_BITS(FB), .DEST_BITS(DB), .DEPTH(DEPTH), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .busy(busy0), .data(data0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .pkt_count(pkt_count0), .misroute_count(misroute_count0), .drop_count(drop_count0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of delivered flits plus a packet-in-flight window
    logic [FB-1:0] m_q[$];
    logic [FB-1:0] m_flit;
    logic [15:0]   m_pkt;
    logic [15:0]   m_mis;
    logic [15:0]   m_drop;
    bit            m_active;
    bit            m_drop_flag;
    int            m_start;
    int            cyc;
    bit            rdy_rand;

    // One clock: check head before the edge, advance model at the edge, check busy/counters after it
    task automatic step();
        bit pop_now;
        int k;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        check_eq("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check_eq("out_data", 32'(out_data), 32'(m_q[0]));
        pop_now = out_ready && (m_q.size() > 0) && !reset;
        if (!reset) begin
            if (!m_active && data) begin
                m_active    = 1'b1;
                m_start     = cyc;
                m_drop_flag = (m_q.size() == DEPTH);
            end else if (m_active) begin
                k = cyc - m_start;
                if (k >= 1 && k <= FB) m_flit[k-1] = data;
            end
        end
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_pkt = '0; m_mis = '0; m_drop = '0;
            m_active = 1'b0;
        end else begin
            if (pop_now) void'(m_q.pop_front());
            if (m_active && cyc == m_start + FB + 1) begin
                if (m_drop_flag) begin
                    m_drop = m_drop + 16'd1;
                end else begin
                    m_q.push_back(m_flit);
                    m_pkt = m_pkt + 16'd1;
                    if (int'(m_flit) % 16 != ID) m_mis = m_mis + 16'd1;
                end
            end
            if (m_active && cyc == m_start + FB + 1 + GAP) m_active = 1'b0;
        end
        cyc++;
        #1;
        check_eq("busy", 32'(busy), 32'(m_active || m_q.size() == DEPTH));
        check_eq("pkt_count", 32'(pkt_count), 32'(m_pkt));
        check_eq("misroute_count", 32'(misroute_count), 32'(m_mis));
        check_eq("drop_count", 32'(drop_count), 32'(m_drop));
    endtask

    task automatic idle(input int n);
        data = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle_model();
        int n = 0;
        while (m_active && n < 100) begin step(); n++; end
        if (m_active) check_eq("wait_model_idle", 32'(m_active), 32'd0);
    endtask

    task automatic send(input logic [FB-1:0] f, input bit ignore_busy);
        int n = 0;
        data = 1'b0;
        if (!ignore_busy) begin
            while (busy && n < 300) begin step(); n++; end
            if (busy) check_eq("busy_wait_timeout", 32'(busy), 32'd0);
        end
        data = 1'b1;
        step();
        for (int i = 0; i < FB; i++) begin
            data = f[i];
            step();
        end
        data = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        data  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [FB-1:0] f;
        logic [15:0]   exp_mis0;
        reset = 1'b1; data = 1'b0; out_ready = 1'b0;
        data0 = 1'b0; out_ready0 = 1'b1;
        rdy_rand = 1'b0; cyc = 0; m_active = 1'b0;
        m_pkt = '0; m_mis = '0; m_drop = '0; m_flit = '0; m_start = 0; m_drop_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_pkt", 32'(pkt_count), 32'd0);
        check_eq("rst_mis", 32'(misroute_count), 32'd0);
        check_eq("rst_drop", 32'(drop_count), 32'd0);
        check_eq("rst_busy0", 32'(busy0), 32'd0);
        check_eq("rst_valid0", 32'(out_valid0), 32'd0);
        reset = 1'b0;

        // Single correctly-routed flit
        out_ready = 1'b1;
        send(8'hA5, 1'b0);
        idle(4);
        check_eq("a5_pkt", 32'(pkt_count), 32'd1);
        check_eq("a5_mis", 32'(misroute_count), 32'd0);

        // Misrouted flit
        do_reset();
        send(8'h53, 1'b0);
        idle(4);
        check_eq("53_mis", 32'(misroute_count), 32'd1);

        // Fill the FIFO, force a start while full, then drain
        do_reset();
        out_ready = 1'b0;
        send(8'h11, 1'b0);
        send(8'h25, 1'b0);
        send(8'h3C, 1'b0);
        send(8'h45, 1'b0);
        idle(6);
        check_eq("full_busy", 32'(busy), 32'd1);
        wait_idle_model();
        send(8'hEE, 1'b1);
        idle(6);
        check_eq("full_drop", 32'(drop_count), 32'd1);
        check_eq("full_pkt", 32'(pkt_count), 32'd4);
        out_ready = 1'b1;
        idle(6);

        // Reset in the middle of a packet, then a clean packet
        f = 8'hC7;
        data = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin data = f[i]; step(); end
        data = f[4];
        reset = 1'b1;
        step();
        reset = 1'b0;
        data = 1'b0;
        idle(2);
        send(8'h15, 1'b0);
        idle(4);
        check_eq("mid_rst_pkt", 32'(pkt_count), 32'd1);

        // Packet counter wrap
        force dut.r_pkt_cnt = 16'hFFFF;
        #1;
        release dut.r_pkt_cnt;
        m_pkt = 16'hFFFF;
        idle(1);
        send(8'h65, 1'b0);
        idle(4);
        check_eq("wrap_pkt", 32'(pkt_count), 32'd0);

        // Randomized traffic with random consumer stalls and occasional forced starts
        rdy_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            f = FB'($urandom);
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0 && m_q.size() == DEPTH && !m_active) send(f, 1'b1);
            else send(f, 1'b0);
        end
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        idle(20);

        // GAP=0 instance: start bits every 10 cycles, busy low exactly one cycle between
        exp_mis0 = '0;
        for (int p = 0; p < 6; p++) begin
            f = FB'($urandom);
            if (int'(f) % 16 != ID) exp_mis0 = exp_mis0 + 16'd1;
            for (int c = 0; c < 10; c++) begin
                data0 = (c == 0) ? 1'b1 : ((c <= FB) ? f[c-1] : 1'b0);
                step();
                check_eq("g0_busy", 32'(busy0), 32'(c != 9));
                if (c == 9) begin
                    check_eq("g0_valid", 32'(out_valid0), 32'd1);
                    check_eq("g0_data", 32'(out_data0), 32'(f));
                end
            end
        end
        data0 = 1'b0;
        idle(3);
        check_eq("g0_pkt", 32'(pkt_count0), 32'd6);
        check_eq("g0_drop", 32'(drop_count0), 32'd0);
        check_eq("g0_mis", 32'(misroute_count0), 32'(exp_mis0));
        check_eq("g0_empty", 32'(out_valid0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
